a2d_sched: RTL and testbench

Round-robin scheduler that sequences the SPI A2D converter across the e-bike's four analog sensors (battery, current, brake, torque) and holds the latest 12-bit reading of each. Sits between the SPI monarch and the sensor-conditioning path. It issues the two-transaction convert/read sequence per channel on a periodic trigger and publishes results as registered outputs.

---
 rtl/a2d_sched.sv | 144 ++++++++++++++
 tb/tb_a2d_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_sched.sv
// rtl/a2d_sched.sv - round-robin A2D channel scheduler with per-channel result registers
// Optional build macro: CURR_PRIORITY_EN (6-slot order, current sampled 3x as often)
module a2d_sched #(
  parameter int FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] resp,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        cnv_cmplt,
  output logic        busy
);

  localparam int CW = (FAST_SIM != 0) ? 10 : 14;

`ifdef CURR_PRIORITY_EN
  localparam logic [2:0] LAST_SLOT = 3'd5;
`else
  localparam logic [2:0] LAST_SLOT = 3'd3;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CNV   = 3'd1,
    WAIT1 = 3'd2,
    GAP   = 3'd3,
    RD    = 3'd4,
    WAIT2 = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] tmr;
  logic          trig;
  logic [2:0]    slot;
  logic [2:0]    chan;

  // Upper response bits carry no data from the converter.
  logic unused_resp;
  assign unused_resp = ^resp[15:12];

  assign trig = &tmr;

  // Free-running trigger period counter; wraps without stopping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  // Map the slot pointer onto the physical A2D channel number.
  always_comb begin
    chan = 3'd0;
    case (slot)
`ifdef CURR_PRIORITY_EN
      3'd0: chan = 3'd0;
      3'd1: chan = 3'd1;
      3'd2: chan = 3'd3;
      3'd3: chan = 3'd1;
      3'd4: chan = 3'd4;
      3'd5: chan = 3'd1;
`else
      3'd0: chan = 3'd0;
      3'd1: chan = 3'd1;
      3'd2: chan = 3'd3;
      3'd3: chan = 3'd4;
`endif
      default: chan = 3'd0;
    endcase
  end

  // Convert/read sequencer with registered strobes, command word and results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      slot      <= 3'd0;
      wrt       <= 1'b0;
      cmd       <= 16'h0000;
      busy      <= 1'b0;
      cnv_cmplt <= 1'b0;
      batt      <= 12'h000;
      curr      <= 12'h000;
      brake     <= 12'h000;
      torque    <= 12'h000;
    end else begin
      wrt       <= 1'b0;
      cnv_cmplt <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            state <= CNV;
            wrt   <= 1'b1;
            cmd   <= {2'b00, chan, 11'h000};
            busy  <= 1'b1;
          end
        end
        CNV: begin
          state <= WAIT1;
        end
        WAIT1: begin
          // Response to the convert command is meaningless and dropped.
          if (done) begin
            state <= GAP;
          end
        end
        GAP: begin
          state <= RD;
          wrt   <= 1'b1;
          cmd   <= 16'h0000;
        end
        RD: begin
          state <= WAIT2;
        end
        WAIT2: begin
          if (done) begin
            case (chan)
              3'd0:    batt   <= resp[11:0];
              3'd1:    curr   <= resp[11:0];
              3'd3:    brake  <= resp[11:0];
              3'd4:    torque <= resp[11:0];
              default: ;
            endcase
            cnv_cmplt <= 1'b1;
            busy      <= 1'b0;
            slot      <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_sched.sv
// tb/tb_a2d_sched.sv - self-checking bench for a2d_sched
module tb_a2d_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;
  logic [11:0] batt, curr, brake, torque;
  logic        cnv_cmplt;
  logic        busy;

  a2d_sched #(.FAST_SIM(1)) dut (
    .clk(clk), .rst_n(rst_n), .wrt(wrt), .cmd(cmd), .done(done), .resp(resp),
    .batt(batt), .curr(curr), .brake(brake), .torque(torque),
    .cnv_cmplt(cnv_cmplt), .busy(busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

`ifdef CURR_PRIORITY_EN
  localparam int NS = 6;
`else
  localparam int NS = 4;
`endif

  logic [2:0]  ord [NS];
  int          slot;
  logic [11:0] mreg [5];

  typedef struct {
    logic [2:0]  chan;
    logic [11:0] val;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [15:0] resp;
    logic [2:0]  chan;
    logic [11:0] b, c, k, t;
  } vec_t;
  vec_t tbl[$];

  int   wrt_consec = 0;
  logic wrt_d = 1'b0;

  always @(negedge clk) begin
    if (wrt === 1'b1 && wrt_d === 1'b1) wrt_consec++;
    wrt_d = wrt;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_batt"},   batt,   mreg[0]);
    chk({tag, "_curr"},   curr,   mreg[1]);
    chk({tag, "_brake"},  brake,  mreg[3]);
    chk({tag, "_torque"}, torque, mreg[4]);
  endtask

  task automatic wait_wrt(output int cyc, output int cm);
    cyc = -1;
    cm  = 0;
    for (int i = 1; i <= 2100; i++) begin
      @(negedge clk);
      done = 1'b0;
      if (cnv_cmplt) cm++;
      if (wrt) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) begin
      total++;
      $display("FAIL wrt_timeout: got no wrt expected wrt within 2100 cycles");
    end
  endtask

  // One full convert/read sequence driven by a simple SPI monarch model.
  task automatic do_conv(input logic [15:0] r, input int exp_wait, input int stall,
                         input bit spur, output logic [2:0] seen_chan);
    int          cyc, cm, extra;
    logic [15:0] ec;
    sb_t         e, s;
    wait_wrt(cyc, cm);
    chk("idle_no_cmplt", cm, 0);
    seen_chan = cmd[13:11];
    ec = {2'b00, ord[slot], 11'h000};
    chk("cnv_cmd", cmd, ec);
    chk("cnv_busy", busy, 1);
    if (exp_wait >= 0) chk("trig_latency", cyc, exp_wait);
    extra = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (wrt) extra++;
    end
    if (stall > 0) chk("overrun_no_wrt", extra, 0);
    @(negedge clk); done = 1'b1; resp = 16'hDEAD;
    @(negedge clk); done = spur; resp = 16'hBEEF;
    chk("gap_wrt_low", wrt, 0);
    chk("gap_busy", busy, 1);
    @(negedge clk); done = 1'b0;
    chk("rd_wrt", wrt, 1);
    chk("rd_cmd", cmd, 16'h0000);
    @(negedge clk);
    chk("wait2_wrt_low", wrt, 0);
    @(negedge clk); done = 1'b1; resp = r;
    e.chan = ord[slot];
    e.val  = r[11:0];
    sbq.push_back(e);
    @(negedge clk); done = 1'b0;
    chk("cmplt", cnv_cmplt, 1);
    chk("cmplt_busy_low", busy, 0);
    if (cnv_cmplt && sbq.size() > 0) begin
      s = sbq.pop_front();
      mreg[s.chan] = s.val;
      slot = (slot + 1) % NS;
    end
    check_regs("latch");
    @(negedge clk);
    chk("cmplt_single", cnv_cmplt, 0);
  endtask

  initial begin : main
    logic [2:0] sc;
    int         cu;
    int         cyc, cm;
    logic [11:0] prev_curr;

`ifdef CURR_PRIORITY_EN
    ord[0] = 3'd0; ord[1] = 3'd1; ord[2] = 3'd3; ord[3] = 3'd1; ord[4] = 3'd4; ord[5] = 3'd1;
    tbl.push_back('{16'h0222, 3'd1, 12'h123, 12'h222, 12'h000, 12'h000});
    tbl.push_back('{16'h7333, 3'd3, 12'h123, 12'h222, 12'h333, 12'h000});
    tbl.push_back('{16'h0555, 3'd1, 12'h123, 12'h555, 12'h333, 12'h000});
    tbl.push_back('{16'h0444, 3'd4, 12'h123, 12'h555, 12'h333, 12'h444});
    tbl.push_back('{16'h0666, 3'd1, 12'h123, 12'h666, 12'h333, 12'h444});
    tbl.push_back('{16'hA111, 3'd0, 12'h111, 12'h666, 12'h333, 12'h444});
`else
    ord[0] = 3'd0; ord[1] = 3'd1; ord[2] = 3'd3; ord[3] = 3'd4;
    tbl.push_back('{16'h0222, 3'd1, 12'h123, 12'h222, 12'h000, 12'h000});
    tbl.push_back('{16'h7333, 3'd3, 12'h123, 12'h222, 12'h333, 12'h000});
    tbl.push_back('{16'h0444, 3'd4, 12'h123, 12'h222, 12'h333, 12'h444});
    tbl.push_back('{16'hA111, 3'd0, 12'h111, 12'h222, 12'h333, 12'h444});
`endif
    for (int i = 0; i < 5; i++) mreg[i] = 12'h000;
    slot = 0;

    rst_n = 1'b0; done = 1'b0; resp = 16'h0000;
    @(negedge clk); @(negedge clk);
    chk("rst_wrt", wrt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmplt", cnv_cmplt, 0);
    chk("rst_cmd", cmd, 16'h0000);
    check_regs("rst");
    rst_n = 1'b1;

    do_conv(16'hF123, 1024, 0, 1'b1, sc);
    chk("first_chan", sc, 3'd0);

    @(negedge clk); done = 1'b1; resp = 16'hFFFF;
    @(negedge clk); done = 1'b0;
    chk("idle_done_cmplt", cnv_cmplt, 0);
    chk("idle_done_busy", busy, 0);
    chk("idle_done_wrt", wrt, 0);
    check_regs("idle_done");

    cu = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      prev_curr = curr;
      do_conv(tbl[i].resp, -1, 0, 1'b0, sc);
      chk("tbl_chan", sc, tbl[i].chan);
      chk("tbl_batt", batt, tbl[i].b);
      chk("tbl_curr", curr, tbl[i].c);
      chk("tbl_brake", brake, tbl[i].k);
      chk("tbl_torque", torque, tbl[i].t);
      if (curr !== prev_curr) cu++;
    end
`ifdef CURR_PRIORITY_EN
    chk("curr_updates", cu, 3);
`else
    chk("curr_updates", cu, 1);
`endif

    do_conv(16'h0ABC, -1, 1100, 1'b0, sc);
    chk("overrun_chan", sc, 3'd1);
    do_conv(16'h0DEF, -1, 0, 1'b0, sc);
    chk("after_overrun_chan", sc, 3'd3);

    wait_wrt(cyc, cm);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) mreg[i] = 12'h000;
    slot = 0;
    chk("midrst_wrt", wrt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd", cmd, 16'h0000);
    check_regs("midrst");
    rst_n = 1'b1;
    done  = 1'b1;
    resp  = 16'h0FFF;
    do_conv(16'h0456, 1024, 0, 1'b0, sc);
    chk("post_rst_chan", sc, 3'd0);

    chk("wrt_never_consecutive", wrt_consec, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
